// File: rtl/switch_allocator_rr_pkg.sv
// Shared constants and types for the 5-port router switch allocator.
// Optional feature macro: SWITCH_ALLOC_STARVATION_GUARD_EN (adds the per-input age default).
package switch_allocator_rr_pkg;

  localparam int NUM_PORTS = 5;
  localparam int N_IN      = NUM_PORTS;
  localparam int M_OUT     = NUM_PORTS;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef logic [0:N_IN-1][0:M_OUT-1] req_matrix_t;
  typedef logic [0:M_OUT-1][0:N_IN-1] grant_matrix_t;

`ifdef SWITCH_ALLOC_STARVATION_GUARD_EN
  localparam int AGE_W_DEFAULT = 4;
`endif

endpackage

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with a registered priority pointer.
// A non-zero force_req overrides the pointer: the lowest-index forced requester wins.
module rr_arbiter_n #(
  parameter int N     = 5,
  parameter int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [0:N-1]     req,
  input  logic [0:N-1]     force_req,
  output logic [0:N-1]     gnt,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] winner;
  logic             found;

  always_comb begin
    int idx;
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (en && !reset) begin
      if (|force_req) begin
        for (int i = 0; i < N; i++) begin
          if (!found && force_req[i]) begin
            found  = 1'b1;
            winner = PTR_W'(i);
          end
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(ptr) + k) % N;
          if (!found && req[idx]) begin
            found  = 1'b1;
            winner = PTR_W'(idx);
          end
        end
      end
      if (found) gnt[winner] = 1'b1;
    end
  end

  // Next search starts just past the winner, so it becomes lowest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(winner) == N-1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/switch_allocator_rr.sv
// Per-output round-robin switch allocator; grants are combinational, pointers registered.
// Optional feature macro: SWITCH_ALLOC_STARVATION_GUARD_EN (per-input age counters, o_starved port).
module switch_allocator_rr
  import switch_allocator_rr_pkg::*;
#(
  parameter int N = N_IN,
  parameter int M = M_OUT
`ifdef SWITCH_ALLOC_STARVATION_GUARD_EN
  , parameter int AGE_W = AGE_W_DEFAULT
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [0:M-1]                 i_en,
  input  logic [0:N-1][0:M-1]          i_output_req,
  output logic [0:M-1][0:N-1]          o_output_grant,
  output logic [0:N-1]                 o_input_grant,
  output logic [0:M-1]                 o_data_val,
  output logic [0:M-1][$clog2(N)-1:0]  o_ptr
`ifdef SWITCH_ALLOC_STARVATION_GUARD_EN
  , output logic [0:N-1]               o_starved
`endif
);

  localparam int PTR_W = $clog2(N);

  logic [0:N-1][0:M-1] clean_req;
  logic [0:M-1][0:N-1] cand;
  logic [0:M-1][0:N-1] force_req;
  logic [0:N-1]        arb_gnt [M];
  logic [PTR_W-1:0]    arb_ptr [M];

  // A row with several outputs requested keeps only its lowest-index output.
  always_comb begin
    clean_req = '0;
    for (int i = 0; i < N; i++) begin
      for (int o = 0; o < M; o++) begin
        if (i_output_req[i][o] && !(|clean_req[i])) clean_req[i][o] = 1'b1;
      end
    end
  end

  always_comb begin
    cand = '0;
    for (int o = 0; o < M; o++) begin
      for (int i = 0; i < N; i++) begin
        cand[o][i] = clean_req[i][o];
      end
    end
  end

  for (genvar o = 0; o < M; o++) begin : g_arb
    rr_arbiter_n #(.N(N), .PTR_W(PTR_W)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .en        (i_en[o]),
      .req       (cand[o]),
      .force_req (force_req[o]),
      .gnt       (arb_gnt[o]),
      .ptr       (arb_ptr[o])
    );
  end

  always_comb begin
    o_output_grant = '0;
    o_input_grant  = '0;
    o_data_val     = '0;
    o_ptr          = '0;
    for (int o = 0; o < M; o++) begin
      o_output_grant[o] = arb_gnt[o];
      o_data_val[o]     = |arb_gnt[o];
      o_ptr[o]          = arb_ptr[o];
      for (int i = 0; i < N; i++) begin
        o_input_grant[i] = o_input_grant[i] | arb_gnt[o][i];
      end
    end
  end

`ifdef SWITCH_ALLOC_STARVATION_GUARD_EN
  logic [AGE_W-1:0] age [N];
  logic [0:N-1]     has_req;

  always_comb begin
    has_req   = '0;
    o_starved = '0;
    for (int i = 0; i < N; i++) begin
      has_req[i]   = |clean_req[i];
      o_starved[i] = &age[i];
    end
  end

  always_comb begin
    force_req = '0;
    for (int o = 0; o < M; o++) begin
      for (int i = 0; i < N; i++) begin
        force_req[o][i] = cand[o][i] & o_starved[i];
      end
    end
  end

  // Age counts consecutive denied cycles and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        age[i] <= '0;
      end else if (has_req[i] && !o_input_grant[i]) begin
        if (!o_starved[i]) age[i] <= age[i] + 1'b1;
      end else begin
        age[i] <= '0;
      end
    end
  end
`else
  assign force_req = '0;
`endif

endmodule
